// File: rtl/hockey_step_scheduler_pkg.sv
// Shared phase encodings, serve codes and phase classification helpers
// for the air-hockey step scheduler.
package hockey_pkg;

  typedef logic [2:0] phase_t;

  localparam phase_t PH_IDLE  = 3'd0;
  localparam phase_t PH_WAIT  = 3'd1;
  localparam phase_t PH_SERVE = 3'd2;
  localparam phase_t PH_MOVE  = 3'd3;
  localparam phase_t PH_RESP  = 3'd4;

  localparam logic [1:0] SERVE_A = 2'b01;
  localparam logic [1:0] SERVE_B = 2'b10;

  // Phases in which the step divider runs.
  function automatic logic phase_timed(input phase_t p);
    return (p == PH_WAIT) || (p == PH_MOVE) || (p == PH_RESP);
  endfunction

  // Undefined encodings 5-7 behave as IDLE.
  function automatic logic phase_is_idle(input phase_t p);
    return !((p == PH_WAIT) || (p == PH_SERVE) || (p == PH_MOVE) || (p == PH_RESP));
  endfunction

endpackage

// File: rtl/hockey_step_scheduler_if.sv
// Signal bundle between the game FSM / board inputs and the step scheduler.
interface hockey_step_scheduler_if;
  import hockey_pkg::*;

  logic       btn_a_raw;
  logic       btn_b_raw;
  phase_t     phase;
  logic       phase_start;
  logic       hit_ok;
  logic       rally_clr;
  logic       step;
  logic       phase_done;
  logic       btn_a_evt;
  logic       btn_b_evt;
  logic       serve_vld;
  logic [1:0] serve_sel;
  logic [2:0] speed_lvl;

  modport master (
    output btn_a_raw, btn_b_raw, phase, phase_start, hit_ok, rally_clr,
    input  step, phase_done, btn_a_evt, btn_b_evt, serve_vld, serve_sel, speed_lvl
  );

  modport slave (
    input  btn_a_raw, btn_b_raw, phase, phase_start, hit_ok, rally_clr,
    output step, phase_done, btn_a_evt, btn_b_evt, serve_vld, serve_sel, speed_lvl
  );
endinterface

// File: rtl/hockey_step_scheduler_btn_debounce.sv
// Button conditioner: two-flop synchroniser, stability counter, and a
// one-cycle pulse on each accepted rising edge.
module btn_debounce #(
  parameter int DEB_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic evt
);
  localparam int CW = $clog2(DEB_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  logic          sync1_reg, sync2_reg, deb_reg, evt_reg;
  logic [CW-1:0] cnt_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_reg <= 1'b0;
      sync2_reg <= 1'b0;
      deb_reg   <= 1'b0;
      evt_reg   <= 1'b0;
      cnt_reg   <= '0;
    end else begin
      sync1_reg <= raw;
      sync2_reg <= sync1_reg;
      evt_reg   <= 1'b0;
      // Any cycle where the synced value agrees with the accepted one restarts the count.
      if (sync2_reg != deb_reg) begin
        if (cnt_reg == CNT_LAST) begin
          deb_reg <= sync2_reg;
          evt_reg <= sync2_reg;
          cnt_reg <= '0;
        end else begin
          cnt_reg <= cnt_reg + CNT_ONE;
        end
      end else begin
        cnt_reg <= '0;
      end
    end
  end

  assign evt = evt_reg;
endmodule

// File: rtl/hockey_step_scheduler.sv
// Step pacing, WAIT/RESP window timing, rally speed level and serve
// arbitration for the air-hockey game FSM.
module hockey_step_scheduler
  import hockey_pkg::*;
#(
  parameter int DIV_W      = 26,
  parameter int BASE_DIV   = 50_000_000,
  parameter int DIV_STEP   = 5_000_000,
  parameter int MAX_LVL    = 4,
  parameter int DEB_CYCLES = 1_000_000,
  parameter int WAIT_STEPS = 2,
  parameter int RESP_STEPS = 2
) (
  input logic                    clk,
  input logic                    rst,
  hockey_step_scheduler_if.slave bus
);
  localparam logic [DIV_W-1:0] BASE_D  = DIV_W'(BASE_DIV);
  localparam logic [DIV_W-1:0] STEP_D  = DIV_W'(DIV_STEP);
  localparam logic [DIV_W-1:0] DIV_ONE = DIV_W'(1);
  localparam logic [2:0]       MAX_L   = 3'(MAX_LVL);
  localparam logic [7:0]       WAIT_N  = 8'(WAIT_STEPS);
  localparam logic [7:0]       RESP_N  = 8'(RESP_STEPS);

  logic [1:0] raw, evt;
  assign raw = {bus.btn_b_raw, bus.btn_a_raw};

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_btn
      btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb (
        .clk (clk),
        .rst (rst),
        .raw (raw[gi]),
        .evt (evt[gi])
      );
    end
  endgenerate

  logic [DIV_W-1:0] div_reg, cur_div_reg, lvl_div;
  logic [7:0]       cnt_reg, cnt_inc;
  logic             done_reg;
  logic [2:0]       lvl_reg, lvl_next;
  logic             timed, windowed, at_wrap, step_next, done_next;

  always_comb begin
    timed     = phase_timed(bus.phase);
    windowed  = (bus.phase == PH_WAIT) || (bus.phase == PH_RESP);
    at_wrap   = (div_reg == cur_div_reg - DIV_ONE);
    step_next = timed && !done_reg && !bus.phase_start && at_wrap;
    cnt_inc   = cnt_reg + 8'd1;
    done_next = step_next &&
                (((bus.phase == PH_WAIT) && (cnt_inc == WAIT_N)) ||
                 ((bus.phase == PH_RESP) && (cnt_inc == RESP_N)));
    lvl_next  = lvl_reg;
    if (bus.rally_clr)
      lvl_next = 3'd0;
    else if (bus.hit_ok && (lvl_reg < MAX_L))
      lvl_next = lvl_reg + 3'd1;
    lvl_div   = BASE_D - DIV_W'(lvl_reg) * STEP_D;
  end

  // The period only changes at a step boundary or phase entry, never mid-count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_reg     <= '0;
      cur_div_reg <= BASE_D;
      cnt_reg     <= '0;
      done_reg    <= 1'b0;
      lvl_reg     <= '0;
    end else begin
      lvl_reg <= lvl_next;
      if (bus.phase_start) begin
        div_reg     <= '0;
        cnt_reg     <= '0;
        done_reg    <= 1'b0;
        cur_div_reg <= lvl_div;
      end else if (timed && !done_reg) begin
        if (at_wrap) begin
          div_reg     <= '0;
          cur_div_reg <= lvl_div;
          if (windowed) cnt_reg <= cnt_inc;
          if (done_next) done_reg <= 1'b1;
        end else begin
          div_reg <= div_reg + DIV_ONE;
        end
      end else begin
        div_reg <= '0;
      end
    end
  end

  logic       serve_vld_reg, lock_reg;
  logic [1:0] serve_sel_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      serve_vld_reg <= 1'b0;
      serve_sel_reg <= 2'b00;
      lock_reg      <= 1'b0;
    end else begin
      serve_vld_reg <= 1'b0;
      if (!phase_is_idle(bus.phase)) begin
        lock_reg <= 1'b0;
      end else if (!lock_reg && (evt != 2'b00)) begin
        serve_vld_reg <= 1'b1;
        serve_sel_reg <= evt[0] ? SERVE_A : SERVE_B;
        lock_reg      <= 1'b1;
      end
    end
  end

  assign bus.step       = step_next;
  assign bus.phase_done = done_next;
  assign bus.btn_a_evt  = evt[0];
  assign bus.btn_b_evt  = evt[1];
  assign bus.serve_vld  = serve_vld_reg;
  assign bus.serve_sel  = serve_sel_reg;
  assign bus.speed_lvl  = lvl_reg;
endmodule

// File: tb/tb_hockey_step_scheduler.sv
// Directed bench for hockey_step_scheduler: per-cycle pulse masks compared
// against hand-computed cycle positions.
module tb_hockey_step_scheduler;
  import hockey_pkg::*;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  hockey_step_scheduler_if bus();

  hockey_step_scheduler #(
    .DIV_W(8), .BASE_DIV(8), .DIV_STEP(2), .MAX_LVL(2),
    .DEB_CYCLES(3), .WAIT_STEPS(2), .RESP_STEPS(2)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end else begin
      $display("check %s ok value=%0h", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Bit k of each mask = output seen in the k-th cycle after the call.
  task automatic run(input int n, output logic [63:0] step_m, output logic [63:0] done_m,
                     output logic [63:0] a_m, output logic [63:0] b_m, output logic [63:0] vld_m);
    step_m = '0; done_m = '0; a_m = '0; b_m = '0; vld_m = '0;
    for (int k = 1; k <= n; k++) begin
      tick();
      bus.phase_start = 1'b0;
      bus.hit_ok      = 1'b0;
      bus.rally_clr   = 1'b0;
      #1;
      step_m[k] = bus.step;
      done_m[k] = bus.phase_done;
      a_m[k]    = bus.btn_a_evt;
      b_m[k]    = bus.btn_b_evt;
      vld_m[k]  = bus.serve_vld;
    end
  endtask

  function automatic logic [63:0] outs();
    return {51'd0, bus.step, bus.phase_done, bus.btn_a_evt, bus.btn_b_evt,
            bus.serve_vld, bus.serve_sel, bus.speed_lvl};
  endfunction

  logic [63:0] sm, dm, am, bm, vm;

  initial begin
    rst = 1'b1;
    bus.btn_a_raw = 1'b0; bus.btn_b_raw = 1'b0;
    bus.phase = PH_IDLE; bus.phase_start = 1'b0;
    bus.hit_ok = 1'b0; bus.rally_clr = 1'b0;
    tick(); tick();
    check("reset_outputs", outs(), 64'd0);
    rst = 1'b0;
    tick();
    check("post_reset_outputs", outs(), 64'd0);

    // Short glitch is rejected, long press gives one event 5 clk after rise.
    bus.phase = PH_SERVE;
    bus.btn_a_raw = 1'b1;
    tick(); tick();
    bus.btn_a_raw = 1'b0;
    run(10, sm, dm, am, bm, vm);
    check("deb_glitch_no_evt", am, 64'd0);
    bus.btn_a_raw = 1'b1;
    run(10, sm, dm, am, bm, vm);
    check("deb_press_evt_at5", am, 64'd1 << 5);
    check("deb_no_serve_outside_idle", vm, 64'd0);
    bus.btn_a_raw = 1'b0;
    run(8, sm, dm, am, bm, vm);
    check("deb_release_no_evt", am, 64'd0);

    // Serve arbitration: simultaneous press, A wins; then locked.
    bus.phase = PH_IDLE;
    bus.btn_a_raw = 1'b1; bus.btn_b_raw = 1'b1;
    run(10, sm, dm, am, bm, vm);
    check("serve_vld_once", vm, 64'd1 << 6);
    check("serve_b_evt_emitted", bm, 64'd1 << 5);
    check("serve_sel_a", {62'd0, bus.serve_sel}, {62'd0, SERVE_A});
    bus.btn_a_raw = 1'b0; bus.btn_b_raw = 1'b0;
    run(8, sm, dm, am, bm, vm);
    bus.btn_b_raw = 1'b1;
    run(10, sm, dm, am, bm, vm);
    check("serve_locked_no_vld", vm, 64'd0);
    check("serve_locked_b_evt", bm, 64'd1 << 5);
    bus.btn_b_raw = 1'b0;
    run(8, sm, dm, am, bm, vm);
    check("serve_sel_held", {62'd0, bus.serve_sel}, {62'd0, SERVE_A});
    bus.phase = PH_SERVE;
    run(2, sm, dm, am, bm, vm);
    bus.phase = PH_IDLE;
    bus.btn_b_raw = 1'b1;
    run(10, sm, dm, am, bm, vm);
    check("serve_rearm_vld", vm, 64'd1 << 6);
    check("serve_sel_b", {62'd0, bus.serve_sel}, {62'd0, SERVE_B});
    bus.btn_b_raw = 1'b0;
    run(8, sm, dm, am, bm, vm);

    // MOVE: free-running steps every 8 clk; SERVE stops them.
    bus.phase = PH_MOVE; bus.phase_start = 1'b1;
    run(30, sm, dm, am, bm, vm);
    check("move_steps", sm, (64'd1 << 8) | (64'd1 << 16) | (64'd1 << 24));
    check("move_no_done", dm, 64'd0);
    bus.phase = PH_SERVE;
    run(20, sm, dm, am, bm, vm);
    check("serve_no_step", sm, 64'd0);

    // RESP and WAIT windows: two steps, done on the second, then silence.
    bus.phase = PH_RESP; bus.phase_start = 1'b1;
    run(40, sm, dm, am, bm, vm);
    check("resp_steps", sm, (64'd1 << 8) | (64'd1 << 16));
    check("resp_done", dm, 64'd1 << 16);
    bus.phase = PH_WAIT; bus.phase_start = 1'b1;
    run(40, sm, dm, am, bm, vm);
    check("wait_steps", sm, (64'd1 << 8) | (64'd1 << 16));
    check("wait_done", dm, 64'd1 << 16);

    // Speed-up: three hit_ok saturate at 2, period becomes 4 after the current one.
    bus.phase = PH_MOVE; bus.phase_start = 1'b1;
    sm = '0;
    for (int k = 1; k <= 22; k++) begin
      tick();
      bus.phase_start = 1'b0;
      bus.hit_ok = (k >= 2 && k <= 4);
      #1;
      sm[k] = bus.step;
      if (k == 6) check("speed_saturated", {61'd0, bus.speed_lvl}, 64'd2);
    end
    check("speed_steps", sm, (64'd1 << 8) | (64'd1 << 12) | (64'd1 << 16) | (64'd1 << 20));
    bus.hit_ok = 1'b1; bus.rally_clr = 1'b1;
    tick();
    bus.hit_ok = 1'b0; bus.rally_clr = 1'b0;
    #1;
    check("rally_clr_wins", {61'd0, bus.speed_lvl}, 64'd0);

    // Async reset mid-MOVE while a button is held.
    bus.phase = PH_MOVE; bus.phase_start = 1'b1; bus.hit_ok = 1'b1;
    bus.btn_a_raw = 1'b1;
    run(8, sm, dm, am, bm, vm);
    check("pre_rst_step", sm, 64'd1 << 8);
    check("pre_rst_a_evt", am, 64'd1 << 5);
    check("pre_rst_lvl", {61'd0, bus.speed_lvl}, 64'd1);
    rst = 1'b1;
    #1;
    check("rst_async_outputs", outs(), 64'd0);
    tick(); tick();
    rst = 1'b0;
    run(10, sm, dm, am, bm, vm);
    check("post_rst_held_btn_evt", am, 64'd1 << 5);
    bus.btn_a_raw = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
